dshot_output: RTL and testbench

DSHOT_OUTPUT -- requirements
Module: dshot_output

---
 rtl/dshot_pkg.sv | 32 +++
 rtl/dshot_crc.sv | 15 +
 rtl/dshot_output.sv | 163 ++++++++++++++++
 tb/tb_dshot_output.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dshot_pkg.sv
// -----------------------------------------------------------------------------
// dshot_pkg
// Shared DShot protocol constants, the transmitter state encoding and a helper
// that forms the 11-bit frame value from a speed or command request.
// -----------------------------------------------------------------------------
package dshot_pkg;

    localparam int          DSHOT_FRAME_W    = 16;
    localparam logic [5:0]  DSHOT_CMD_MAX    = 6'd47;
    localparam logic [10:0] DSHOT_THR_OFFSET = 11'd48;
    localparam logic [10:0] DSHOT_SPEED_MAX  = 11'd1999;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        GAP
    } dshotStateT;

    // Commands occupy values 0..47; throttle is shifted above them so that
    // speed 0 still encodes as a non-command value.
    function automatic logic [10:0] frameValue(
        input logic        isCmd,
        input logic [10:0] speedIn,
        input logic [5:0]  commandIn
    );
        logic [10:0] clamped;
        clamped = (speedIn > DSHOT_SPEED_MAX) ? DSHOT_SPEED_MAX : speedIn;
        return isCmd ? {5'd0, commandIn} : clamped + DSHOT_THR_OFFSET;
    endfunction

endpackage

// File: rtl/dshot_crc.sv
// -----------------------------------------------------------------------------
// dshot_crc
// Combinational DShot checksum: XOR of the three nibbles of the 12-bit payload
// (value + telemetry bit). Shared by the transmit and receive paths.
//   data : 12-bit payload, frame[15:4]
//   crc  : 4-bit checksum, frame[3:0]
// -----------------------------------------------------------------------------
module dshot_crc (
    input  logic [11:0] data,
    output logic [3:0]  crc
);

    assign crc = data[3:0] ^ data[7:4] ^ data[11:8];

endmodule

// File: rtl/dshot_output.sv
// -----------------------------------------------------------------------------
// dshot_output
// DShot frame transmitter. Accepts a speed or command request through a
// valid/ready handshake, builds the 16-bit frame (value, telemetry, checksum)
// and drives it MSB first as pulse-width coded bits, followed by a low gap.
//   clk, reset   : clock, synchronous active-high reset
//   frame_valid  : request present      frame_ready : request can be taken
//   speed        : throttle 0..1999     command     : special command 0..47
//   is_command   : send command         telemetry   : telemetry request bit
//   out_pin      : DShot line (registered, idle low)
//   busy         : frame or gap in progress
//   frame_done   : one-cycle pulse on return to IDLE after the gap
//   cmd_error    : one-cycle pulse after a rejected out-of-range command
// -----------------------------------------------------------------------------
module dshot_output
    import dshot_pkg::*;
#(
    parameter int CLK_HZ   = 16000000,
    parameter int BAUD     = 150000,
    parameter int GAP_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [10:0] speed,
    input  logic [5:0]  command,
    input  logic        is_command,
    input  logic        telemetry,
    output logic        out_pin,
    output logic        busy,
    output logic        frame_done,
    output logic        cmd_error
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int T1H     = (BIT_CYC * 3) / 4;
    localparam int T0H     = (BIT_CYC * 3) / 8;
    localparam int GAP_CYC = GAP_BITS * BIT_CYC;
    localparam int MAX_CYC = (GAP_CYC > BIT_CYC) ? GAP_CYC : BIT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cntT;

    // Terminal counts: each phase lasts (LAST + 1) cycles.
    localparam cntT HIGH1_LAST = cntT'(T1H - 1);
    localparam cntT HIGH0_LAST = cntT'(T0H - 1);
    localparam cntT LOW1_LAST  = cntT'(BIT_CYC - T1H - 1);
    localparam cntT LOW0_LAST  = cntT'(BIT_CYC - T0H - 1);
    localparam cntT GAP_LAST   = cntT'(GAP_CYC - 1);

    dshotStateT             state, stateNext;
    cntT                    cnt, cntNext;
    logic [3:0]             bitIdx;
    logic [DSHOT_FRAME_W-1:0] shiftReg;

    logic        accept;
    logic        cmdBad;
    logic        loadFrame;
    logic        shiftBit;
    logic        gapDone;
    logic        curBit;
    logic [10:0] value;
    logic [11:0] crcData;
    logic [3:0]  crcOut;
    cntT         highLast;
    cntT         lowLast;

    // Frame assembly from the live inputs; only captured on acceptance.
    assign value   = frameValue(is_command, speed, command);
    assign crcData = {value, telemetry};

    dshot_crc uCrc (
        .data (crcData),
        .crc  (crcOut)
    );

    assign frame_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = frame_valid && frame_ready;
    assign cmdBad      = is_command && (command > DSHOT_CMD_MAX);

    assign curBit   = shiftReg[DSHOT_FRAME_W-1];
    assign highLast = curBit ? HIGH1_LAST : HIGH0_LAST;
    assign lowLast  = curBit ? LOW1_LAST  : LOW0_LAST;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        cntNext   = cnt + 1'b1;
        loadFrame = 1'b0;
        shiftBit  = 1'b0;
        gapDone   = 1'b0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (accept && !cmdBad) begin
                    stateNext = HIGH;
                    loadFrame = 1'b1;
                end
            end
            HIGH: begin
                if (cnt == highLast) begin
                    stateNext = LOW;
                    cntNext   = '0;
                end
            end
            LOW: begin
                if (cnt == lowLast) begin
                    cntNext = '0;
                    if (bitIdx == 4'd0) begin
                        stateNext = GAP;
                    end else begin
                        stateNext = HIGH;
                        shiftBit  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                    gapDone   = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bitIdx     <= 4'd0;
            shiftReg   <= '0;
            out_pin    <= 1'b0;
            frame_done <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (loadFrame) begin
                shiftReg <= {crcData, crcOut};
                bitIdx   <= 4'd15;
            end else if (shiftBit) begin
                shiftReg <= {shiftReg[DSHOT_FRAME_W-2:0], 1'b0};
                bitIdx   <= bitIdx - 4'd1;
            end
            // Registered from the next state so the line rises on the
            // acceptance edge and stays high exactly while in HIGH.
            out_pin    <= (stateNext == HIGH);
            frame_done <= gapDone;
            cmd_error  <= accept && cmdBad;
        end
    end

endmodule

// File: tb/tb_dshot_output.sv
// -----------------------------------------------------------------------------
// tb_dshot_output
// Scoreboard bench for dshot_output at default parameters (106-cycle bits,
// 79/39-cycle highs, 212-cycle gap). The stimulus process pushes hand-computed
// frames; a monitor decodes out_pin, checks pulse timing and compares frames.
// -----------------------------------------------------------------------------
module tb_dshot_output;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [10:0] speed = '0;
    logic [5:0]  command = '0;
    logic        is_command = 1'b0;
    logic        telemetry = 1'b0;
    logic        out_pin;
    logic        busy;
    logic        frame_done;
    logic        cmd_error;

    always #5 clk = ~clk;

    dshot_output dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .speed       (speed),
        .command     (command),
        .is_command  (is_command),
        .telemetry   (telemetry),
        .out_pin     (out_pin),
        .busy        (busy),
        .frame_done  (frame_done),
        .cmd_error   (cmd_error)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nAssert = 0;
    int          nFail   = 0;
    logic [15:0] expQ[$];
    int          doneCount = 0;
    bit          expectSpacing = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic        prevPin;
        logic        pendingDone;
        logic [15:0] curExp;
        logic [15:0] decoded;
        int          bitCnt;
        int          highLen;
        int          lastRise;
        int          frameStart;
        prevPin = 1'b0; pendingDone = 1'b0; curExp = '0; decoded = '0;
        bitCnt = 0; highLen = 0; lastRise = 0; frameStart = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevPin     = 1'b0;
                pendingDone = 1'b0;
                bitCnt      = 0;
                highLen     = 0;
            end else begin
                if (out_pin && !prevPin) begin
                    check("rise_outside_gap", pendingDone, 1'b0);
                    if (bitCnt == 0) begin
                        nAssert++;
                        if (expQ.size() == 0) begin
                            nFail++;
                            $display("FAIL unexpected_frame: rise at cycle %0d, nothing queued", cyc);
                            curExp = '0;
                        end else begin
                            curExp = expQ.pop_front();
                        end
                        decoded = '0;
                        if (expectSpacing) begin
                            check("frame_spacing", cyc - frameStart, 1909);
                            expectSpacing = 1'b0;
                        end
                        frameStart = cyc;
                    end else begin
                        check("bit_period", cyc - lastRise, 106);
                    end
                    lastRise = cyc;
                    highLen  = 1;
                end else if (out_pin) begin
                    highLen++;
                end else if (prevPin) begin
                    check("bit_high_len", highLen, curExp[15 - bitCnt] ? 79 : 39);
                    decoded = {decoded[14:0], (highLen == 79)};
                    bitCnt++;
                    if (bitCnt == 16) begin
                        check("frame_value", decoded, curExp);
                        bitCnt      = 0;
                        pendingDone = 1'b1;
                    end
                end
                if (frame_done) begin
                    doneCount++;
                    check("done_expected", pendingDone, 1'b1);
                    // Last bit period (106) plus the full gap (212).
                    if (pendingDone) check("done_timing", cyc - lastRise, 318);
                    pendingDone = 1'b0;
                end
                prevPin = out_pin;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic sendReq(input logic isCmd, input logic [10:0] spd,
                           input logic [5:0] cmd, input logic tel);
        @(posedge clk); #1;
        is_command  = isCmd;
        speed       = spd;
        command     = cmd;
        telemetry   = tel;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs right after acceptance; the frame must not move.
        frame_valid = 1'b0;
        speed       = 11'h2AA;
        command     = 6'h15;
        is_command  = ~isCmd;
        telemetry   = ~tel;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check("idle_within_budget", busy, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int doneBefore;
        int n;
        int busyCycles;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_pin",     out_pin,     1'b0);
        check("reset_busy",        busy,        1'b0);
        check("reset_frame_done",  frame_done,  1'b0);
        check("reset_cmd_error",   cmd_error,   1'b0);
        check("reset_frame_ready", frame_ready, 1'b1);

        // Speed 0 -> value 48.
        expQ.push_back(16'h0606);
        sendReq(1'b0, 11'd0, 6'd0, 1'b0);
        waitIdle(2500);

        // Command 0 with telemetry.
        expQ.push_back(16'h0011);
        sendReq(1'b1, 11'd0, 6'd0, 1'b1);
        waitIdle(2500);

        // Out-of-range command: rejected, nothing transmitted.
        @(posedge clk); #1;
        is_command = 1'b1; command = 6'd50; speed = '0; telemetry = 1'b0;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        check("cmd_error_pulse",       cmd_error,   1'b1);
        check("cmd_error_frame_ready", frame_ready, 1'b1);
        check("cmd_error_busy",        busy,        1'b0);
        @(posedge clk); #1;
        check("cmd_error_one_cycle",   cmd_error,   1'b0);
        busyCycles = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_pin || busy || !frame_ready) busyCycles++;
        end
        check("cmd_error_line_quiet", busyCycles, 0);

        // Throttle clamp: 1999 and two larger 11-bit values encode the same.
        expQ.push_back(16'hFFEE);
        sendReq(1'b0, 11'd1999, 6'd0, 1'b0);
        waitIdle(2500);
        expQ.push_back(16'hFFEE);
        sendReq(1'b0, 11'd2000, 6'd0, 1'b0);
        waitIdle(2500);
        expQ.push_back(16'hFFEE);
        sendReq(1'b0, 11'd2047, 6'd0, 1'b0);
        waitIdle(2500);

        // Back-to-back with frame_valid held: A = speed 1046 + telemetry,
        // then inputs switch to B = command 47 while A is in flight.
        doneBefore = doneCount;
        @(posedge clk); #1;
        is_command = 1'b0; speed = 11'd1046; command = 6'd0; telemetry = 1'b1;
        frame_valid = 1'b1;
        expQ.push_back(16'h88DD);
        @(posedge clk); #1;
        is_command = 1'b1; speed = 11'd7; command = 6'd47; telemetry = 1'b0;
        expQ.push_back(16'h05EB);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2500);
        check("b2b_first_done", frame_done, 1'b1);
        expectSpacing = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        is_command = 1'b0; speed = 11'd5; command = 6'd3; telemetry = 1'b1;
        waitIdle(2500);
        check("b2b_done_count", doneCount - doneBefore, 2);

        // Reset during bit 7 of a speed-0 frame.
        doneBefore = doneCount;
        expQ.push_back(16'h0606);
        sendReq(1'b0, 11'd0, 6'd0, 1'b0);
        repeat (762) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_pin_low", out_pin, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_frame_ready", frame_ready, 1'b1);
        check("reset_mid_busy",        busy,        1'b0);
        repeat (400) @(negedge clk);
        check("reset_mid_no_done", doneCount - doneBefore, 0);

        // A fresh request after the abort: speed 100.
        expQ.push_back(16'h128B);
        sendReq(1'b0, 11'd100, 6'd0, 1'b0);
        waitIdle(2500);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
